onehot_rr_bus_arbiter: RTL and testbench
========================================

// Module: onehot_rr_bus_arbiter
// PURPOSE
//   N-master bus arbiter built as a one-hot state machine with IDLE and ARB states and one MSTR state per master.
//   Takes active-low bus requests plus a bus "done" (turnaround complete) strobe, and drives active-low grants.
//   Selectable fixed or round-robin priority; an optional hold timeout forces the owner off when others wait.
//   Sits between the bus masters' request logic and the shared-bus mux/decoder.
// PARAMETERS
//   NMASTER  4   number of masters, 2..16
//   RR_MODE  1   1 = round-robin priority, 0 = fixed priority (lowest index wins)
//   TIMEOUT  16  max owner cycles while another master waits; 0 = no timeout, 1..255 otherwise
// PORTS
//   clk      in   1              rising-edge clock
//   rst_n    in   1              synchronous reset, active-low
//   nreq     in   NMASTER        per-master request, active-low
//   done     in   1              bus turnaround complete; grant may be issued
//   state    out  NMASTER+2      one-hot: [0]=IDLE, [1]=ARB, [2+i]=MSTR_i
//   ngnt     out  NMASTER        per-master grant, active-low; ngnt[i] = ~state[2+i]
//   owner    out  clog2(NMASTER) index of current/last granted master
//   tmo      out  1              1-cycle pulse when an owner is forcibly released
// BEHAVIOUR
//   All outputs are registered. Exactly one state bit is set in every cycle, including the cycle after reset.
//   Reset (rst_n=0 at a clk edge), also mid-grant:
//     state=IDLE, ngnt=all 1, owner=0, tmo=0, hold counter=0.
//     The RR pointer resets to NMASTER-1, so master 0 has first priority.
//   IDLE: any nreq bit low -> ARB; otherwise stay in IDLE.
//   ARB:
//     - No request -> IDLE.
//     - Requests present but done=0 -> stay in ARB.
//     - done=1 and requests present -> MSTR_w.
//     - Winner w with RR_MODE=1: first requester scanning ptr+1, ptr+2, ... with modulo-NMASTER wrap.
//     - Winner w with RR_MODE=0: lowest requesting index.
//     - On entering MSTR_w: owner<=w, ptr<=w, counter<=0.
//   Grant latency: ARB with done=1 at edge k gives ngnt[w]=0 after edge k+1. Minimum request->grant is 2 cycles from IDLE.
//   MSTR_i:
//     - Counter increments each cycle while any other nreq bit is low, saturating at TIMEOUT.
//     - Counter holds while no other master requests.
//     - Release if nreq[i]=1: go to ARB if another master requests, else IDLE.
//     - Forced release if TIMEOUT!=0, counter==TIMEOUT-1 and another master requests: go to ARB, tmo=1 for exactly 1 cycle.
//     - A released master still requesting competes normally. In RR mode it is lowest priority on the next ARB.
//   Simultaneous events: own release and timeout in the same cycle -> normal release, tmo=0.
//   The requested master drops nreq in the same cycle as the grant edge: MSTR is still entered for 1 cycle, then released.
//   No combinational path from inputs to outputs.
// TESTING
//   1. Reset with nreq=4'b1111.
//      -> state=6'b000001, ngnt=4'b1111. Assert rst_n=0 mid-MSTR_2 -> IDLE next cycle.
//   2. nreq=4'b1110 (M0), done=1.
//      -> ARB at cycle 1, ngnt=4'b1110 and owner=0 at cycle 2. nreq[0]=1 -> IDLE next cycle.
//   3. RR_MODE=1, all four masters request continuously, each releases after 3 cycles.
//      -> grant order 0,1,2,3,0 (wrap).
//      RR_MODE=0 with the same stimulus -> M0 wins every ARB.
//   4. done=0 held 5 cycles in ARB with nreq=4'b0111.
//      -> stays in ARB, ngnt=4'b1111. Then done=1 -> M3 granted next cycle.
//   5. TIMEOUT=4, M1 owns the bus and never releases, M2 requests.
//      -> after 4 waiting cycles: tmo pulses once, ARB, M2 granted.
//      With M2 idle instead -> M1 keeps the bus indefinitely, tmo=0.
//   6. Random nreq/done for 10k cycles.
//      -> state always one-hot, at most one ngnt bit low, never a grant without a prior request.

Source files
------------

// File: rtl/onehot_rr_bus_arbiter.sv
// N-master bus arbiter. The FSM is one-hot: IDLE, ARB, and one MSTR state per master.
// Requests and grants are active-low. Priority is fixed or round-robin, and an optional
// hold timeout forces the current owner off the bus while other masters are waiting.
module onehot_rr_bus_arbiter #(
    parameter int NMASTER = 4,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 16,
    localparam int OW     = $clog2(NMASTER)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NMASTER-1:0]   nreq,
    input  logic                 done,
    output logic [NMASTER+1:0]   state,
    output logic [NMASTER-1:0]   ngnt,
    output logic [OW-1:0]        owner,
    output logic                 tmo
);

    localparam logic [NMASTER+1:0] S_IDLE = (NMASTER+2)'(1);
    localparam logic [NMASTER+1:0] S_ARB  = (NMASTER+2)'(2);
    localparam logic [7:0]         TO_SAT = 8'(TIMEOUT);
    localparam logic [7:0]         TO_HIT = 8'(TIMEOUT - 1);

    logic [NMASTER+1:0] r_state;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_ptr;
    logic [7:0]         r_cnt;
    logic               r_tmo;

    logic [NMASTER-1:0] w_req;
    logic               w_any;
    logic               w_others;
    logic               w_own_rel;
    logic               w_found;
    logic [OW-1:0]      w_win;

    assign w_req     = ~nreq;
    assign w_any     = |w_req;
    assign w_others  = |(w_req & ~(NMASTER'(1) << r_owner));
    assign w_own_rel = nreq[r_owner];

    // Winner selection: in round-robin mode scan upward from ptr+1 and wrap; otherwise lowest index wins
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NMASTER; k++) begin
                if (!w_found && w_req[OW'((int'(r_ptr) + k) % NMASTER)]) begin
                    w_found = 1'b1;
                    w_win   = OW'((int'(r_ptr) + k) % NMASTER);
                end
            end
        end else begin
            for (int k = NMASTER - 1; k >= 0; k--) begin
                if (w_req[k]) w_win = OW'(k);
            end
        end
    end

    // FSM, owner/pointer tracking, hold counter and timeout pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= OW'(NMASTER - 1);
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            if (r_state[0]) begin
                if (w_any) r_state <= S_ARB;
            end else if (r_state[1]) begin
                if (!w_any) begin
                    r_state <= S_IDLE;
                end else if (done) begin
                    r_state <= (NMASTER+2)'(1) << (int'(w_win) + 2);
                    r_owner <= w_win;
                    r_ptr   <= w_win;
                    r_cnt   <= '0;
                end
            end else begin
                // Own release beats a coincident timeout, so tmo stays low in that case
                if (w_own_rel) begin
                    r_state <= w_others ? S_ARB : S_IDLE;
                end else if (TIMEOUT != 0 && r_cnt == TO_HIT && w_others) begin
                    r_state <= S_ARB;
                    r_tmo   <= 1'b1;
                end else if (w_others && r_cnt < TO_SAT) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign state = r_state;
    assign ngnt  = ~r_state[NMASTER+1:2];
    assign owner = r_owner;
    assign tmo   = r_tmo;

endmodule

// File: tb/tb_onehot_rr_bus_arbiter.sv
// Scoreboard bench. Two arbiters (round-robin with TIMEOUT=4, and fixed priority with no
// timeout) share the same stimulus. A behavioural model pushes the expected outputs for
// every cycle, and a monitor pops and compares them.
module tb_onehot_rr_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] nreq = 4'hf;
    logic       done = 1'b0;

    logic [1:0][5:0] d_st;
    logic [1:0][3:0] d_ng;
    logic [1:0][1:0] d_own;
    logic [1:0]      d_tmo;

    always #5 clk = ~clk;

    onehot_rr_bus_arbiter #(.NMASTER(4), .RR_MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .nreq(nreq), .done(done),
        .state(d_st[0]), .ngnt(d_ng[0]), .owner(d_own[0]), .tmo(d_tmo[0]));

    onehot_rr_bus_arbiter #(.NMASTER(4), .RR_MODE(0), .TIMEOUT(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .nreq(nreq), .done(done),
        .state(d_st[1]), .ngnt(d_ng[1]), .owner(d_own[1]), .tmo(d_tmo[1]));

    typedef struct packed {
        logic [1:0][5:0] st;
        logic [1:0][3:0] ng;
        logic [1:0][1:0] own;
        logic [1:0]      tmo;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // model: mode 0=idle 1=arb 2=owned
    int cfg_rr[2] = '{1, 0};
    int cfg_to[2] = '{4, 0};
    int m_mode[2], m_own[2], m_ptr[2], m_cnt[2], m_tmo[2];
    int held = 0;

    function automatic int pick(int k, logic [3:0] rq);
        if (cfg_rr[k] != 0) begin
            for (int d = 1; d <= 4; d++)
                if (!rq[(m_ptr[k] + d) % 4]) return (m_ptr[k] + d) % 4;
        end else begin
            for (int j = 0; j < 4; j++)
                if (!rq[j]) return j;
        end
        return 0;
    endfunction

    task automatic model(int k, bit rst, logic [3:0] rq, bit dn);
        bit oth;
        if (!rst) begin
            m_mode[k] = 0; m_own[k] = 0; m_ptr[k] = 3; m_cnt[k] = 0; m_tmo[k] = 0;
            return;
        end
        m_tmo[k] = 0;
        case (m_mode[k])
            0: if (rq != 4'hf) m_mode[k] = 1;
            1: begin
                if (rq == 4'hf) m_mode[k] = 0;
                else if (dn) begin
                    m_own[k] = pick(k, rq);
                    m_ptr[k] = m_own[k];
                    m_cnt[k] = 0;
                    m_mode[k] = 2;
                end
            end
            default: begin
                oth = 0;
                for (int j = 0; j < 4; j++)
                    if (j != m_own[k] && !rq[j]) oth = 1;
                if (rq[m_own[k]]) m_mode[k] = oth ? 1 : 0;
                else if (cfg_to[k] != 0 && m_cnt[k] == cfg_to[k] - 1 && oth) begin
                    m_mode[k] = 1;
                    m_tmo[k] = 1;
                end else if (oth && m_cnt[k] < cfg_to[k]) m_cnt[k]++;
            end
        endcase
    endtask

    task automatic step(bit rst, logic [3:0] rq, bit dn);
        exp_t e;
        @(negedge clk);
        rst_n = rst; nreq = rq; done = dn;
        for (int k = 0; k < 2; k++) begin
            model(k, rst, rq, dn);
            e.st[k]  = (m_mode[k] == 0) ? 6'b000001 : (m_mode[k] == 1) ? 6'b000010 : 6'(6'd4 << m_own[k]);
            e.ng[k]  = (m_mode[k] == 2) ? ~4'(4'd1 << m_own[k]) : 4'hf;
            e.own[k] = 2'(m_own[k]);
            e.tmo[k] = m_tmo[k][0];
        end
        q.push_back(e);
        held = (m_mode[0] == 2) ? held + 1 : 0;
    endtask

    task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0h exp=%0h", nm, k, $time, got, exp);
        end
    endtask

    // monitor: every cycle the DUTs present outputs; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk("state", k, 32'(d_st[k]), 32'(e.st[k]));
                    chk("ngnt", k, 32'(d_ng[k]), 32'(e.ng[k]));
                    chk("owner", k, 32'(d_own[k]), 32'(e.own[k]));
                    chk("tmo", k, 32'(d_tmo[k]), 32'(e.tmo[k]));
                    chk("onehot", k, 32'($onehot(d_st[k])), 32'd1);
                    chk("gnt_le1", k, 32'($countones(~d_ng[k]) <= 1), 32'd1);
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        // reset, then reset while M2 owns the bus
        repeat (2) step(0, 4'hf, 0);
        step(1, 4'b1011, 1);
        step(1, 4'b1011, 1);
        step(1, 4'b1011, 1);
        step(0, 4'b1011, 1);
        step(1, 4'hf, 1);
        // single M0 request and release
        step(1, 4'b1110, 1);
        step(1, 4'b1110, 1);
        step(1, 4'b1111, 1);
        step(1, 4'b1111, 1);
        // all request, owner releases after 3 cycles held
        for (int c = 0; c < 40; c++) begin
            rq = 4'b0000;
            if (m_mode[0] == 2 && held >= 3) rq[m_own[0]] = 1'b1;
            step(1, rq, 1);
        end
        repeat (2) step(1, 4'hf, 1);
        // done held low in ARB, then M3 granted
        step(1, 4'b0111, 0);
        repeat (5) step(1, 4'b0111, 0);
        step(1, 4'b0111, 1);
        step(1, 4'b0111, 1);
        repeat (2) step(1, 4'hf, 1);
        // M1 holds forever; M2 waits -> timeout on the round-robin instance
        step(1, 4'b1101, 1);
        step(1, 4'b1101, 1);
        repeat (10) step(1, 4'b1001, 1);
        repeat (20) step(1, 4'b1101, 1);
        repeat (2) step(1, 4'hf, 1);
        // random traffic
        for (int c = 0; c < 10000; c++) begin
            rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq = 4'hf;
            step(($urandom_range(0, 499) != 0), rq, ($urandom_range(0, 2) != 0));
        end
        repeat (3) @(negedge clk);
        chk("drain", 0, 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
